// File: rtl/gate2_resp_checker.sv
// gate2_resp_checker
//
// Self-test sequencer and response checker for any 2-input combinational
// gate. It walks the gate inputs through {B,A} = 0,1,2,3 and holds each
// vector for HOLD cycles. At the end of each hold window it samples the gate
// output and compares it with the expected truth table TT. The result is
// reported as a saturating mismatch count plus a pass flag.
//
// Parameters
//   TT    expected X per vector, indexed by {B,A} (AND=1000, OR=1110,
//         NAND=0111, XOR=0110)
//   HOLD  clock cycles each vector is held, 2..1023
//   ERRW  width of the mismatch counter
//
// Ports
//   clk       single clock, rising edge
//   rst_n     synchronous active-low reset, has priority over start
//   start     one-cycle request to run a check; ignored while busy
//   outA/outB registered drives to gate inputs A/B
//   inX       gate output X, assumed synchronous to clk
//   busy      high while a check runs
//   done      high from completion until the next start or reset
//   pass      valid while done=1; 1 iff err_cnt==0
//   err_cnt   mismatch count, saturating at 2^ERRW-1
//
// Optional build macro GATE2_FAIL_CAPTURE_EN adds first-failure capture:
//   ff_valid  a mismatch has been captured in this run
//   ff_idx    vector index {B,A} of the first mismatch
//   ff_x      gate output observed at the first mismatch
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, drives 00, waiting for start
// DRIVE | applying vectors 0..3 and sampling X at the end of each window
// DONE  | run complete, results held until the next start or reset

module gate2_resp_checker #(
  parameter logic [3:0] TT   = 4'b1000,
  parameter int         HOLD = 50,
  parameter int         ERRW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            outA,
  output logic            outB,
  input  logic            inX,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_cnt
`ifdef GATE2_FAIL_CAPTURE_EN
  ,
  output logic            ff_valid,
  output logic [1:0]      ff_idx,
  output logic            ff_x
`endif
);

  localparam logic [9:0]      HOLD_LAST = 10'(HOLD - 1);
  localparam logic [ERRW-1:0] ERR_MAX   = {ERRW{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, stateNext;
  logic [1:0]      vecIdx, vecIdxNext;
  logic [9:0]      holdCnt, holdCntNext;
  logic            armed, armedNext;
  logic [ERRW-1:0] errNext;
  logic            passNext;
  logic            outANext, outBNext;

  logic            sampleMiss;
  logic [ERRW-1:0] errSampled;

`ifdef GATE2_FAIL_CAPTURE_EN
  logic            ffValidNext;
  logic [1:0]      ffIdxNext;
  logic            ffXNext;
`endif

  assign busy = (state == DRIVE);
  assign done = (state == DONE);

  // Compare against the expected bit for the vector currently on the gate.
  assign sampleMiss = (inX != TT[vecIdx]);
  assign errSampled = !sampleMiss ? err_cnt
                    : (err_cnt == ERR_MAX) ? err_cnt
                    : err_cnt + {{(ERRW-1){1'b0}}, 1'b1};

  always_comb begin
    stateNext   = state;
    vecIdxNext  = vecIdx;
    holdCntNext = holdCnt;
    armedNext   = armed;
    errNext     = err_cnt;
    passNext    = pass;
    outANext    = outA;
    outBNext    = outB;
`ifdef GATE2_FAIL_CAPTURE_EN
    ffValidNext = ff_valid;
    ffIdxNext   = ff_idx;
    ffXNext     = ff_x;
`endif

    case (state)
      IDLE, DONE: begin
        if (start) begin
          stateNext   = DRIVE;
          vecIdxNext  = 2'd0;
          holdCntNext = 10'd0;
          armedNext   = 1'b0;
          errNext     = '0;
          passNext    = 1'b0;
          outANext    = 1'b0;
          outBNext    = 1'b0;
`ifdef GATE2_FAIL_CAPTURE_EN
          ffValidNext = 1'b0;
          ffIdxNext   = 2'd0;
          ffXNext     = 1'b0;
`endif
        end
      end

      DRIVE: begin
        // The accepting edge registers vector 0 onto outA/outB; the hold
        // window starts on the following cycle, which puts completion
        // 4*HOLD+1 edges after the start was accepted.
        if (!armed) begin
          armedNext = 1'b1;
        end else if (holdCnt == HOLD_LAST) begin
          errNext     = errSampled;
          holdCntNext = 10'd0;
`ifdef GATE2_FAIL_CAPTURE_EN
          if (sampleMiss && !ff_valid) begin
            ffValidNext = 1'b1;
            ffIdxNext   = vecIdx;
            ffXNext     = inX;
          end
`endif
          if (vecIdx != 2'd3) begin
            vecIdxNext = vecIdx + 2'd1;
            outANext   = vecIdxNext[0];
            outBNext   = vecIdxNext[1];
          end else begin
            stateNext = DONE;
            passNext  = (errSampled == '0);
            outANext  = 1'b0;
            outBNext  = 1'b0;
          end
        end else begin
          holdCntNext = holdCnt + 10'd1;
        end
      end

      default: begin
        stateNext = IDLE;
        outANext  = 1'b0;
        outBNext  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      vecIdx   <= 2'd0;
      holdCnt  <= 10'd0;
      armed    <= 1'b0;
      err_cnt  <= '0;
      pass     <= 1'b0;
      outA     <= 1'b0;
      outB     <= 1'b0;
`ifdef GATE2_FAIL_CAPTURE_EN
      ff_valid <= 1'b0;
      ff_idx   <= 2'd0;
      ff_x     <= 1'b0;
`endif
    end else begin
      state    <= stateNext;
      vecIdx   <= vecIdxNext;
      holdCnt  <= holdCntNext;
      armed    <= armedNext;
      err_cnt  <= errNext;
      pass     <= passNext;
      outA     <= outANext;
      outB     <= outBNext;
`ifdef GATE2_FAIL_CAPTURE_EN
      ff_valid <= ffValidNext;
      ff_idx   <= ffIdxNext;
      ff_x     <= ffXNext;
`endif
    end
  end

endmodule

// File: tb/tb_gate2_resp_checker.sv
// Bench for gate2_resp_checker: two checkers (ERRW=3 and ERRW=2) share the
// start/reset stimulus, each driving its own behavioural gate model with a
// two-cycle settling delay.
module tb_gate2_resp_checker;

  localparam int         HOLD = 4;
  localparam logic [3:0] TT   = 4'b1000;
  localparam int         LAT  = 4 * HOLD + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic outA, outB, inX, busy, done, pass;
  logic [2:0] errCnt;
  logic outA2, outB2, inX2, busy2, done2, pass2;
  logic [1:0] errCnt2;
`ifdef GATE2_FAIL_CAPTURE_EN
  logic ffValid, ffX, ffValid2, ffX2;
  logic [1:0] ffIdx, ffIdx2;
`endif

  gate2_resp_checker #(.TT(TT), .HOLD(HOLD), .ERRW(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .outA(outA), .outB(outB),
    .inX(inX), .busy(busy), .done(done), .pass(pass), .err_cnt(errCnt)
`ifdef GATE2_FAIL_CAPTURE_EN
    , .ff_valid(ffValid), .ff_idx(ffIdx), .ff_x(ffX)
`endif
  );

  gate2_resp_checker #(.TT(TT), .HOLD(HOLD), .ERRW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .outA(outA2), .outB(outB2),
    .inX(inX2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(errCnt2)
`ifdef GATE2_FAIL_CAPTURE_EN
    , .ff_valid(ffValid2), .ff_idx(ffIdx2), .ff_x(ffX2)
`endif
  );

  // Gate models: 0 AND, 1 stuck-at-0, 2 NAND, 3 OR, 4 XOR
  int gateMode = 0;
  function automatic logic gateFn(input int mode, input logic a, input logic b);
    case (mode)
      0: return a & b;
      1: return 1'b0;
      2: return ~(a & b);
      3: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  logic [1:0] settle = 2'b00;
  logic [1:0] settle2 = 2'b00;
  always @(posedge clk) begin
    settle  <= {settle[0], gateFn(gateMode, outA, outB)};
    settle2 <= {settle2[0], gateFn(gateMode, outA2, outB2)};
  end
  assign inX  = settle[1];
  assign inX2 = settle2[1];

  int chkCnt = 0;
  int passCnt = 0;

  task automatic check(input string nm, input int act, input int exp);
    chkCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  typedef struct {
    int mode;
    bit midStart;
    int expErr;
    bit expPass;
    bit ffV;
    int ffI;
    bit ffX;
  } vec_t;

  typedef struct {
    int err;
    int err2;
    bit pass;
    bit ffV;
    int ffI;
    bit ffX;
    int lat;
  } exp_t;

  exp_t sbq[$];

  task automatic runCheck(input vec_t v);
    exp_t e;
    int lat;
    @(negedge clk);
    gateMode = v.mode;
    start = 1'b1;
    e.err  = v.expErr;
    e.err2 = (v.expErr > 3) ? 3 : v.expErr;
    e.pass = v.expPass;
    e.ffV  = v.ffV;
    e.ffI  = v.ffI;
    e.ffX  = v.ffX;
    e.lat  = LAT;
    sbq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (k <= 4 * HOLD) check("drive_vec", {outB, outA}, (k - 1) / HOLD);
      check("busy_run", busy, 1);
      if (k == 1) begin
        check("err_cleared", errCnt, 0);
        check("pass_cleared", pass, 0);
        check("err2_cleared", errCnt2, 0);
      end
      start = (v.midStart && k == 5) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    e = sbq.pop_front();
    check("latency", lat, e.lat);
    check("err_cnt", errCnt, e.err);
    check("pass", pass, e.pass);
    check("busy_done", busy, 0);
    check("outs_idle", {outB, outA}, 0);
    check("done2", done2, 1);
    check("err_cnt2", errCnt2, e.err2);
    check("pass2", pass2, e.pass);
`ifdef GATE2_FAIL_CAPTURE_EN
    check("ff_valid", ffValid, e.ffV);
    check("ff_idx", ffIdx, e.ffI);
    check("ff_x", ffX, e.ffX);
    check("ff_idx2", ffIdx2, e.ffI);
`endif
    repeat (2) @(posedge clk);
    #1;
    check("done_hold", done, 1);
    check("err_hold", errCnt, e.err);
  endtask

  vec_t vecs[8];

  initial begin
    //           mode mid err pass ffV ffI ffX
    vecs[0] = '{0, 1'b0, 0, 1'b1, 1'b0, 0, 1'b0};  // AND, clean
    vecs[1] = '{1, 1'b0, 1, 1'b0, 1'b1, 3, 1'b0};  // stuck-at-0
    vecs[2] = '{2, 1'b0, 4, 1'b0, 1'b1, 0, 1'b1};  // NAND, all wrong
    vecs[3] = '{0, 1'b0, 0, 1'b1, 1'b0, 0, 1'b0};  // restart from DONE after err=4
    vecs[4] = '{2, 1'b1, 4, 1'b0, 1'b1, 0, 1'b1};  // NAND with start while busy
    vecs[5] = '{3, 1'b0, 2, 1'b0, 1'b1, 1, 1'b1};  // OR
    vecs[6] = '{4, 1'b0, 3, 1'b0, 1'b1, 1, 1'b1};  // XOR
    vecs[7] = '{0, 1'b1, 0, 1'b1, 1'b0, 0, 1'b0};  // AND with start while busy

    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {outB, outA}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", errCnt, 0);
    check("rst_err2", errCnt2, 0);
`ifdef GATE2_FAIL_CAPTURE_EN
    check("rst_ff_valid", ffValid, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) runCheck(vecs[i]);

    // Reset during vector 2 of a failing run, then a clean run.
    @(negedge clk);
    gateMode = 2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2 * HOLD + 2) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    check("mid_vec", {outB, outA}, 2);
    check("mid_err", errCnt, 2);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rstmid_outs", {outB, outA}, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_err", errCnt, 0);
    check("rstmid_pass", pass, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rstmid_idle", busy, 0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    check("rst_prio_busy", busy, 0);
    @(posedge clk); #1;
    check("rst_prio_idle", busy, 0);

    runCheck(vecs[0]);

    $display("%0d/%0d checks passed", passCnt, chkCnt);
    $finish;
  end

endmodule
